// File: rtl/eda_output_stream_if.sv
// Output beat stream of eda_output_stream.
//   master (the streamer) drives out_valid/out_data/out_row/out_word/out_last
//   and receives out_ready; slave (the consumer) is the mirror.
interface eda_output_stream_if #(
    parameter int OUT_WIDTH = 8,
    parameter int ROW_W     = 4,
    parameter int WORD_W    = 1
);
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [ROW_W-1:0]     out_row;
    logic [WORD_W-1:0]    out_word;
    logic                 out_last;

    modport master (
        output out_valid, out_data, out_row, out_word, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_word, out_last,
        output out_ready
    );
endinterface

// File: rtl/eda_output_stream.sv
// Snapshots the M x N region-max matrix on start and streams it row-major as
// OUT_WIDTH-bit beats over a valid/ready handshake; done pulses one cycle
// after the final beat is accepted.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         synchronous abort back to IDLE (beats start and handshake)
//   start         take snapshot of matrix_in and begin streaming (IDLE only)
//   matrix_in     result matrix, matrix_in[row][col]
//   out_if        beat stream (master modport)
//   busy          high while streaming
//   done          one-cycle pulse after the last beat is accepted
module eda_output_stream #(
    parameter int M         = 16,
    parameter int N         = 16,
    parameter int OUT_WIDTH = 8,
    localparam int WPR      = (N + OUT_WIDTH - 1) / OUT_WIDTH,
    localparam int ROW_W    = (M > 1) ? $clog2(M) : 1,
    localparam int WORD_W   = (WPR > 1) ? $clog2(WPR) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  start,
    input  logic [M-1:0][N-1:0]   matrix_in,
    eda_output_stream_if.master   out_if,
    output logic                  busy,
    output logic                  done
);
    localparam int PADW = WPR * OUT_WIDTH;
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(M - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WPR - 1);
    localparam logic FIRST_IS_LAST = (M == 1) && (WPR == 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [M-1:0][N-1:0]    snap_q, snap_d;
    logic [ROW_W-1:0]       row_q, row_d, row_nxt;
    logic [WORD_W-1:0]      word_q, word_d, word_nxt;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic                   hs;

    // One beat of a row; bits past column N-1 read as zero.
    function automatic logic [OUT_WIDTH-1:0] word_sel(
        input logic [N-1:0]      row_bits,
        input logic [WORD_W-1:0] w
    );
        logic [PADW-1:0] padded;
        padded         = '0;
        padded[N-1:0]  = row_bits;
        return padded[w*OUT_WIDTH +: OUT_WIDTH];
    endfunction

    assign hs = (state_q == SEND) && out_if.out_ready;

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        row_d    = row_q;
        word_d   = word_q;
        data_d   = data_q;
        last_d   = last_q;
        done_d   = 1'b0;
        row_nxt  = row_q;
        word_nxt = word_q + 1'b1;
        if (word_q == WORD_LAST) begin
            word_nxt = '0;
            row_nxt  = row_q + 1'b1;
        end

        if (clear) begin
            state_d = IDLE;
            row_d   = '0;
            word_d  = '0;
            data_d  = '0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // First beat comes straight from matrix_in so it is
                        // valid the cycle after start, same value as the snapshot.
                        state_d = SEND;
                        snap_d  = matrix_in;
                        row_d   = '0;
                        word_d  = '0;
                        data_d  = word_sel(matrix_in[0], '0);
                        last_d  = FIRST_IS_LAST;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (last_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            row_d   = '0;
                            word_d  = '0;
                            data_d  = '0;
                            last_d  = 1'b0;
                        end else begin
                            row_d  = row_nxt;
                            word_d = word_nxt;
                            data_d = word_sel(snap_q[row_nxt], word_nxt);
                            last_d = (row_nxt == ROW_LAST) && (word_nxt == WORD_LAST);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            row_q   <= '0;
            word_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            row_q   <= row_d;
            word_q  <= word_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign out_if.out_valid = (state_q == SEND);
    assign out_if.out_data  = data_q;
    assign out_if.out_row   = row_q;
    assign out_if.out_word  = word_q;
    assign out_if.out_last  = last_q;
    assign busy             = (state_q == SEND);
    assign done             = done_q;
endmodule

// File: tb/tb_eda_output_stream.sv
module tb_eda_output_stream;
    localparam int M      = 4;
    localparam int N      = 12;
    localparam int W      = 8;
    localparam int WPR    = (N + W - 1) / W;
    localparam int ROW_W  = (M > 1) ? $clog2(M) : 1;
    localparam int WORD_W = (WPR > 1) ? $clog2(WPR) : 1;

    typedef struct packed {
        logic [W-1:0]      data;
        logic [ROW_W-1:0]  row;
        logic [WORD_W-1:0] word;
        logic              last;
    } beat_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                clear = 1'b0;
    logic                start = 1'b0;
    logic [M-1:0][N-1:0] matrix_in = '0;
    logic                busy, done;

    eda_output_stream_if #(.OUT_WIDTH(W), .ROW_W(ROW_W), .WORD_W(WORD_W)) bus ();

    eda_output_stream #(.M(M), .N(N), .OUT_WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .start     (start),
        .matrix_in (matrix_in),
        .out_if    (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    m_send = 0;
    int    m_left = 0;
    bit    exp_done = 0;
    bit    held_v = 0;
    beat_t held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an image is M rows, each cut into WPR little-endian chunks
    // of W bits; the row value shifted right leaves zeros above column N-1.
    task automatic push_image(input logic [M-1:0][N-1:0] mat);
        beat_t b;
        for (int r = 0; r < M; r++) begin
            for (int w = 0; w < WPR; w++) begin
                b.data = W'({{64-N{1'b0}}, mat[r]} >> (w * W));
                b.row  = ROW_W'(r);
                b.word = WORD_W'(w);
                b.last = (r == M - 1) && (w == WPR - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Model of the stream state driven only by bench inputs.
    always @(posedge clk) begin
        if (!reset_n || clear) begin
            m_send = 0;
            exp_q.delete();
        end else if (!m_send) begin
            if (start) begin
                push_image(matrix_in);
                m_send = 1;
                m_left = M * WPR;
            end
        end else if (bus.out_ready) begin
            m_left--;
            if (m_left == 0) m_send = 0;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        beat_t act, e;
        act = '{bus.out_data, bus.out_row, bus.out_word, bus.out_last};
        if (!reset_n) begin
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_done", done, 0);
            exp_done = 0;
            held_v   = 0;
        end else begin
            chk("done", done, exp_done);
            exp_done = 0;
            chk("valid", bus.out_valid, m_send);
            chk("busy", busy, m_send);
            if (held_v && bus.out_valid) chk("hold", act, held);
            held_v = 0;
            if (bus.out_valid && !clear) begin
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", act, 0);
                        if (act == 0) chk("unexpected_beat_flag", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", act, e);
                        exp_done = e.last;
                    end
                end else begin
                    held_v = 1;
                    held   = act;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_matrix();
        for (int r = 0; r < M; r++) matrix_in[r] = N'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_send && n < 300) begin
            cyc();
            n++;
        end
        if (m_send) chk("drain_timeout", 1, 0);
    endtask

    task automatic run_image(input bit random_ready);
        rand_matrix();
        start = 1;
        bus.out_ready = random_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        cyc();
        start = 0;
        for (int n = 0; n < 300 && m_send; n++) begin
            if (random_ready) begin
                bus.out_ready = ($urandom_range(0, 2) != 0);
                start         = ($urandom_range(0, 4) == 0);
            end
            matrix_in = {M{N'($urandom)}};
            cyc();
        end
        start = 0;
        if (m_send) chk("image_timeout", 1, 0);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        repeat (2) cyc();
        chk("reset_data", bus.out_data, 0);
        chk("reset_row", bus.out_row, 0);
        chk("reset_word", bus.out_word, 0);
        chk("reset_last", bus.out_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset_n = 1;
        cyc();

        // Full-rate stream with padding (N not a multiple of W).
        matrix_in[0] = 12'hABC;
        matrix_in[1] = 12'h001;
        matrix_in[2] = 12'hFFF;
        matrix_in[3] = 12'h000;
        bus.out_ready = 1;
        start = 1;
        cyc();
        start = 0;
        matrix_in = '1;
        wait_idle();
        cyc();

        // Directed backpressure 1,0,0,1 then drain.
        rand_matrix();
        start = 1;
        cyc();
        start = 0;
        bus.out_ready = 1; cyc();
        bus.out_ready = 0; cyc();
        bus.out_ready = 0; cyc();
        bus.out_ready = 1;
        wait_idle();

        // Randomized images, back-to-back, random ready and stray starts.
        for (int i = 0; i < 25; i++) begin
            run_image(1);
            if ($urandom_range(0, 1) != 0) repeat ($urandom_range(1, 3)) cyc();
        end
        bus.out_ready = 1;
        run_image(0);
        run_image(0);

        // clear after two beats, then a fresh stream from row 0 word 0.
        rand_matrix();
        bus.out_ready = 1;
        start = 1;
        cyc();
        start = 0;
        cyc();
        clear = 1;
        start = 1;
        cyc();
        clear = 0;
        start = 0;
        cyc();
        run_image(1);

        // Asynchronous reset mid-stream.
        bus.out_ready = 1;
        rand_matrix();
        start = 1;
        cyc();
        start = 0;
        cyc();
        reset_n = 0;
        m_send  = 0;
        exp_q.delete();
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_data", bus.out_data, 0);
        chk("midrst_row", bus.out_row, 0);
        chk("midrst_last", bus.out_last, 0);
        cyc();
        reset_n = 1;
        cyc();
        run_image(1);
        bus.out_ready = 1;
        wait_idle();
        repeat (3) cyc();

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
